// File: rtl/sseg_pkg.sv
// Shared constants for the seven-segment capture block: segment codes,
// legal digit-enable patterns and special digit values.
package sseg_pkg;

    localparam logic [6:0] SEG_DIGITS [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    localparam logic [3:0] AN_DIGIT0 = 4'b1110;
    localparam logic [3:0] AN_DIGIT1 = 4'b1101;
    localparam logic [3:0] AN_DIGIT2 = 4'b1011;
    localparam logic [3:0] AN_DIGIT3 = 4'b0111;
    localparam logic [3:0] BLANK_AN  = 4'b1111;

    localparam logic [3:0] DIGIT_DASH = 4'hF;
    localparam logic [3:0] DIGIT_ERR  = 4'hE;

    typedef enum logic [1:0] {
        AN_BLANK,
        AN_SELECT,
        AN_ILLEGAL
    } an_kind_t;

    function automatic an_kind_t an_kind(input logic [3:0] an);
        case (an)
            AN_DIGIT0, AN_DIGIT1, AN_DIGIT2, AN_DIGIT3: return AN_SELECT;
            BLANK_AN:                                   return AN_BLANK;
            default:                                    return AN_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational seven-segment pattern decoder: digit value, legal flag and dash flag.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] value,
    output logic       legal,
    output logic       dash
);

    always_comb begin
        value = DIGIT_ERR;
        legal = 1'b0;
        dash  = 1'b0;
        if (seg == SEG_DASH) begin
            value = DIGIT_DASH;
            legal = 1'b1;
            dash  = 1'b1;
        end
        for (int unsigned i = 0; i < 10; i++) begin
            if (seg == SEG_DIGITS[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sseg_capture.sv
// Recovers the four digits shown on a multiplexed seven-segment display.
// Optional stale-digit timeout enabled by defining SSEG_CAPTURE_STALE_EN.
module sseg_capture
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE       = 16,
    parameter int unsigned STALE_CYCLES = 2**20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    input  logic       dp,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] valid,
    output logic [3:0] dash,
    output logic       frame_done,
    output logic       err
);

    localparam logic [7:0] SETTLE_MAX = 8'(SETTLE);
    localparam logic [7:0] CAPTURE_AT = 8'(SETTLE - 2);

    logic [3:0] an_s1, an_s2, an_p;
    logic [6:0] seg_s1, seg_s2, seg_p;
    logic       dp_s1, dp_s2;
    logic       unused_dp;
    logic [7:0] settle_cnt;
    logic       stable, capture, illegal_entry;
    an_kind_t   kind;
    logic [3:0] cap_hot, seen;
    logic [3:0] dec_value;
    logic       dec_legal, dec_dash;
    logic [3:0] digit_q [4];
    logic [3:0] valid_q, dash_q;
    logic [3:0] stale_hit;

    assign unused_dp = dp_s2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_s1  <= '1;
            an_s2  <= '1;
            an_p   <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_p  <= '1;
            dp_s1  <= 1'b1;
            dp_s2  <= 1'b1;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            an_p   <= an_s2;
            seg_s1 <= seg;
            seg_s2 <= seg_s1;
            seg_p  <= seg_s2;
            dp_s1  <= dp;
            dp_s2  <= dp_s1;
        end
    end

    sseg_pattern_decode u_decode (
        .seg   (seg_s2),
        .value (dec_value),
        .legal (dec_legal),
        .dash  (dec_dash)
    );

    // Capture fires on the edge that moves the counter to SETTLE-1, so the
    // output update lands 2 + SETTLE cycles after the pins change.
    always_comb begin
        kind          = an_kind(an_s2);
        stable        = (an_s2 == an_p) && (seg_s2 == seg_p);
        capture       = stable && (settle_cnt == CAPTURE_AT) && (kind == AN_SELECT);
        illegal_entry = (kind == AN_ILLEGAL) && (an_s2 != an_p);
        cap_hot       = capture ? ~an_s2 : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            settle_cnt <= '0;
        end else if (!stable || kind == AN_ILLEGAL) begin
            settle_cnt <= '0;
        end else if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 8'd1;
        end
    end

`ifdef SSEG_CAPTURE_STALE_EN
    localparam int unsigned STALE_W = $clog2(STALE_CYCLES + 1);
    logic [STALE_W-1:0] stale_cnt [4];

    always_comb begin
        stale_hit = '0;
        for (int unsigned i = 0; i < 4; i++)
            stale_hit[i] = !cap_hot[i] && (stale_cnt[i] == STALE_W'(STALE_CYCLES - 1));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) stale_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cap_hot[i])
                    stale_cnt[i] <= '0;
                else if (stale_cnt[i] != STALE_W'(STALE_CYCLES))
                    stale_cnt[i] <= stale_cnt[i] + 1'b1;
            end
        end
    end
`else
    localparam int unsigned unused_stale_cycles = STALE_CYCLES;
    assign stale_hit = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 4; i++) digit_q[i] <= '0;
            valid_q <= '0;
            dash_q  <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (cap_hot[i]) begin
                    digit_q[i] <= dec_value;
                    valid_q[i] <= dec_legal;
                    dash_q[i]  <= dec_dash;
                end else if (stale_hit[i]) begin
                    valid_q[i] <= 1'b0;
                    dash_q[i]  <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen       <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            err        <= illegal_entry || (capture && !dec_legal);
            if (capture) begin
                if ((seen | cap_hot) == 4'b1111) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen | cap_hot;
                end
            end
        end
    end

    assign digit0 = digit_q[0];
    assign digit1 = digit_q[1];
    assign digit2 = digit_q[2];
    assign digit3 = digit_q[3];
    assign valid  = valid_q;
    assign dash   = dash_q;

endmodule

// File: tb/tb_sseg_capture.sv
// Self-checking bench for sseg_capture: vector table with capture scoreboard,
// plus hand-written toggle, reset and stale sequences.
module tb_sseg_capture;

    localparam int unsigned SETTLE = 16;
    localparam int unsigned STALE  = 100;

    logic       clock, reset, dp;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] digit0, digit1, digit2, digit3, valid, dash;
    logic       frame_done, err;

    sseg_capture #(.SETTLE(SETTLE), .STALE_CYCLES(STALE)) dut (
        .clock(clock), .reset(reset), .an(an), .seg(seg), .dp(dp),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .valid(valid), .dash(dash), .frame_done(frame_done), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  seg;
        int unsigned hold;
        logic        capt;
        logic [3:0]  val;
        logic        vld;
        logic        dsh;
        int unsigned errs;
        logic        fd;
    } vec_t;

    typedef struct {
        int unsigned pos;
        logic [3:0]  val;
        logic        vld;
        logic        dsh;
    } exp_t;

    vec_t        vecs [14];
    exp_t        sbq [$];
    int unsigned errors = 0, checks = 0;
    int unsigned err_cnt = 0, fd_cnt = 0, cyc = 0;
    logic [3:0]  m_digit [4];
    logic [3:0]  m_valid, m_dash;
    int unsigned m_cap [4];

    always @(negedge clock) begin
        if (err) err_cnt++;
        if (frame_done) fd_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
        dp = 1'($urandom);
    endtask

    function automatic logic [3:0] get_digit(input int unsigned p);
        case (p)
            0: return digit0;
            1: return digit1;
            2: return digit2;
            default: return digit3;
        endcase
    endfunction

    function automatic int unsigned pos_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] live_mask();
        logic [3:0] m;
        m = '1;
`ifdef SSEG_CAPTURE_STALE_EN
        for (int i = 0; i < 4; i++) m[i] = (cyc - m_cap[i]) < STALE;
`endif
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_digit[i] = '0;
            m_cap[i]   = 0;
        end
        m_valid = '0;
        m_dash  = '0;
    endtask

    task automatic compare_all(input string tag);
        for (int i = 0; i < 4; i++)
            check($sformatf("%s digit%0d", tag, i), 32'(get_digit(i)), 32'(m_digit[i]));
        check({tag, " valid"}, 32'(valid), 32'(m_valid & live_mask()));
        check({tag, " dash"}, 32'(dash), 32'(m_dash & live_mask()));
    endtask

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
            return;
        end
        e = sbq.pop_front();
        m_digit[e.pos]  = e.val;
        m_valid[e.pos]  = e.vld;
        m_dash[e.pos]   = e.dsh;
        m_cap[e.pos]    = cyc;
        compare_all({tag, " capture"});
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t        e;
        int unsigned e0, f0;
        e0  = err_cnt;
        f0  = fd_cnt;
        an  = v.an;
        seg = v.seg;
        if (v.capt) begin
            e.pos = pos_of(v.an);
            e.val = v.val;
            e.vld = v.vld;
            e.dsh = v.dsh;
            sbq.push_back(e);
        end
        for (int unsigned c = 1; c <= v.hold; c++) begin
            tick();
            if (v.capt && c == SETTLE + 1) compare_all($sformatf("v%0d pre", idx));
            if (v.capt && c == SETTLE + 2) begin
                pop_and_check($sformatf("v%0d", idx));
                check($sformatf("v%0d frame_done", idx), 32'(frame_done), 32'(v.fd));
            end
        end
        check($sformatf("v%0d err count", idx), err_cnt - e0, v.errs);
        check($sformatf("v%0d frame count", idx), fd_cnt - f0, 32'(v.fd));
        compare_all($sformatf("v%0d end", idx));
    endtask

    initial begin
        int unsigned e0, f0;
        exp_t        e;

        vecs[0]  = '{4'b1110, 7'b0100100, 30, 1'b1, 4'h2, 1'b1, 1'b0, 0, 1'b0};
        vecs[1]  = '{4'b1110, 7'b0011001, 40, 1'b1, 4'h4, 1'b1, 1'b0, 0, 1'b0};
        vecs[2]  = '{4'b1101, 7'b0111111, 40, 1'b1, 4'hF, 1'b1, 1'b1, 0, 1'b0};
        vecs[3]  = '{4'b1011, 7'b1111000, 40, 1'b1, 4'h7, 1'b1, 1'b0, 0, 1'b0};
        vecs[4]  = '{4'b0111, 7'b0010000, 40, 1'b1, 4'h9, 1'b1, 1'b0, 0, 1'b1};
        vecs[5]  = '{4'b1111, 7'b0100100, 30, 1'b0, 4'h0, 1'b0, 1'b0, 0, 1'b0};
        vecs[6]  = '{4'b1110, 7'b1000000, 30, 1'b1, 4'h0, 1'b1, 1'b0, 0, 1'b0};
        vecs[7]  = '{4'b1101, 7'b1111001, 30, 1'b1, 4'h1, 1'b1, 1'b0, 0, 1'b0};
        vecs[8]  = '{4'b1011, 7'b0110000, 30, 1'b1, 4'h3, 1'b1, 1'b0, 0, 1'b0};
        vecs[9]  = '{4'b0111, 7'b0010010, 30, 1'b1, 4'h5, 1'b1, 1'b0, 0, 1'b1};
        vecs[10] = '{4'b1110, 7'b0000010, 30, 1'b1, 4'h6, 1'b1, 1'b0, 0, 1'b0};
        vecs[11] = '{4'b1110, 7'b0000000, 30, 1'b1, 4'h8, 1'b1, 1'b0, 0, 1'b0};
        vecs[12] = '{4'b1100, 7'b1000000, 20, 1'b0, 4'h0, 1'b0, 1'b0, 1, 1'b0};
        vecs[13] = '{4'b0111, 7'b1010101, 30, 1'b1, 4'hE, 1'b0, 1'b0, 1, 1'b0};

        reset = 1'b1;
        an    = 4'b1111;
        seg   = 7'b1111111;
        dp    = 1'b1;
        model_reset();
        repeat (3) tick();
        compare_all("reset");
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

        // Segment code toggling faster than SETTLE never captures.
        e0 = err_cnt;
        an = 4'b1110;
        for (int k = 0; k < 8; k++) begin
            seg = (k % 2 == 0) ? 7'b1111001 : 7'b1111000;
            repeat (8) tick();
        end
        compare_all("toggle");
        check("toggle err count", err_cnt - e0, 0);

        // Reset at settle count 10 of digit 1 discards the pending capture.
        an  = 4'b1101;
        seg = 7'b0100100;
        repeat (13) tick();
        reset = 1'b1;
        repeat (2) tick();
        model_reset();
        compare_all("midreset");
        check("midreset frame_done", 32'(frame_done), 32'd0);
        check("midreset err", 32'(err), 32'd0);
        e0 = err_cnt;
        f0 = fd_cnt;
        reset = 1'b0;
        e.pos = 1;
        e.val = 4'h2;
        e.vld = 1'b1;
        e.dsh = 1'b0;
        sbq.push_back(e);
        for (int unsigned c = 1; c <= SETTLE + 2; c++) begin
            tick();
            if (c <= 3) begin
                check($sformatf("release+%0d frame_done", c), 32'(frame_done), 32'd0);
                check($sformatf("release+%0d err", c), 32'(err), 32'd0);
            end
            if (c == SETTLE + 1) compare_all("release pre");
            if (c == SETTLE + 2) pop_and_check("release");
        end

        // Capture digit 2, then blank and watch for the stale timeout.
        an  = 4'b1011;
        seg = 7'b1111000;
        e.pos = 2;
        e.val = 4'h7;
        sbq.push_back(e);
        repeat (SETTLE + 2) tick();
        pop_and_check("stale");
        an = 4'b1111;
        for (int unsigned k = 1; k <= 120; k++) begin
            tick();
            if (k == STALE - 1 || k == STALE) begin
                check($sformatf("stale+%0d valid", k), 32'(valid), 32'(m_valid & live_mask()));
                check($sformatf("stale+%0d dash", k), 32'(dash), 32'(m_dash & live_mask()));
            end
        end
        check("stale digit2 retained", 32'(digit2), 32'h7);
        compare_all("stale end");
        check("post-reset err count", err_cnt - e0, 0);
        check("post-reset frame count", fd_cnt - f0, 0);
        check("scoreboard drained", sbq.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sseg_capture.md
SSEG_CAPTURE -- requirements
Module: sseg_capture

Interface
REQ-001 Parameter SETTLE, 16, consecutive stable synchronized cycles required before a digit is captured (range 2..255).
REQ-002 Parameter STALE_CYCLES, 2**20, cycles without refresh before a digit's valid bit drops (used only with SSEG_CAPTURE_STALE_EN).
REQ-003 clock  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 an  input  4  digit enables, active-low, an[0] = rightmost digit.
REQ-006 seg  input  7  segment lines {g,f,e,d,c,b,a}, active-low.
REQ-007 dp  input  1  decimal point, active-low; sampled and ignored.
REQ-008 digit0, digit1, digit2, digit3  output  4 each  last captured value per digit position.
REQ-009 valid  output  4  valid[i] = 1 while digit i holds a legal captured value.
REQ-010 dash  output  4  dash[i] = 1 when digit i last captured the dash pattern.
REQ-011 frame_done  output  1  one-cycle pulse when all four positions have been captured since the previous pulse.
REQ-012 err  output  1  one-cycle pulse on an illegal enable pattern or an unknown segment code.

Function
REQ-013 an and seg SHALL pass through a 2-flop synchronizer; all logic below uses synchronized values only.
REQ-014 Legal enables: 4'b1110, 1101, 1011, 0111 select digit 0..3; 4'b1111 = blank, no capture, no error.
REQ-015 Any other enable pattern SHALL pulse err once on entry, clear the settle counter, and capture nothing.
REQ-016 Decode: 1000000->0, 1111001->1, 0100100->2, 0110000->3, 0011001->4, 0010010->5, 0000010->6, 1111000->7, 0000000->8, 0010000->9, 0111111->dash (value 4'hF).
REQ-017 Any other segment code SHALL decode to 4'hE; its capture sets valid[i]=0, dash[i]=0 and pulses err.
REQ-018 Settle counter: cleared whenever synchronized {an,seg} differs from the previous cycle; otherwise increments, saturating at SETTLE.
REQ-019 Capture SHALL occur exactly once per stable activation, on the cycle the counter reaches SETTLE-1, into digit i, valid[i], dash[i].
REQ-020 Latency: pin change to output update = 2 sync cycles + SETTLE cycles.
REQ-021 A legal digit captured SHALL set valid[i]=1; dash[i]=1 only for the dash code.
REQ-022 frame_done SHALL pulse on the capture that completes the set {0,1,2,3}; the set is then cleared; repeat captures of one position SHALL NOT advance it.
REQ-023 err and a capture in the same cycle SHALL both take effect.

Reset
REQ-024 On reset: digit0..3 = 4'h0, valid = 0, dash = 0, frame_done = 0, err = 0, synchronizers = 4'b1111/7'b1111111, settle counter and frame set cleared.
REQ-025 Reset asserted mid-settle or mid-frame SHALL discard all partial state; no capture, frame_done or err within 3 cycles after release.

Configuration
REQ-026 With SSEG_CAPTURE_STALE_EN defined: per-digit counters SHALL clear valid[i] and dash[i] after STALE_CYCLES cycles without a capture of position i; digit i value is retained.
REQ-027 Without SSEG_CAPTURE_STALE_EN: no stale counters exist; valid[i] changes only by capture or reset.

Structure
REQ-028 Package sseg_pkg SHALL hold the ten digit segment codes, the dash code, the four legal enable patterns, BLANK_AN, DIGIT_DASH (4'hF) and DIGIT_ERR (4'hE).
REQ-029 Sub-module sseg_pattern_decode (combinational: 7-bit seg -> 4-bit value, legal flag, dash flag) SHALL implement REQ-016/017.

Verification
REQ-030 Reset, then an=1110, seg=0100100 held 30 cycles -> digit0=2, valid=0001 at cycle 2+SETTLE, no err.
REQ-031 Cycle digits 0..3 with codes for 4,dash,7,9, each held 40 cycles -> digit0..3 = 4,F,7,9, dash=0010, valid=1111, one frame_done on digit 3 capture.
REQ-032 an=1110 with seg toggling every 8 cycles (SETTLE=16) -> no capture, valid unchanged.
REQ-033 an=1100 held 20 cycles -> single err pulse, no capture; then seg=1010101 on an=0111 -> err pulse, digit3=E, valid[3]=0.
REQ-034 Reset asserted at settle count 10 of digit 1 -> all outputs at reset values, no capture after release until fresh SETTLE period.
REQ-035 With SSEG_CAPTURE_STALE_EN, STALE_CYCLES=100: capture digit 2, then an=1111 for 120 cycles -> valid[2] falls at cycle 100, digit2 retained.
